// File: rtl/i2c_passthru_pkg.sv
// Shared definitions for the I2C passthru bus monitors.
package i2c_passthru_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // Bit position of the acknowledge slot within a 9-clock byte frame.
    localparam logic [3:0] ACK_BIT_IDX = 4'd8;

endpackage

// File: rtl/i2c_passthru_edge_detect.sv
// Holds the previous SDA/SCL sample and decodes START, STOP and SCL edges.
module i2c_passthru_edge_detect
    import i2c_passthru_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sda,
    input  logic i_scl,
    output logic o_start,
    output logic o_stop,
    output logic o_rise,
    output logic o_fall
);

    logic sda_q, sda_d;
    logic scl_q, scl_d;

    // Events compare the live input with the previous sample.
    always_comb begin
        sda_d   = i_sda;
        scl_d   = i_scl;
        o_start = scl_q & i_scl & sda_q & ~i_sda;
        o_stop  = scl_q & i_scl & ~sda_q & i_sda;
        o_rise  = ~scl_q & i_scl;
        o_fall  = scl_q & ~i_scl;
    end

    // Reset to an idle-high bus so leaving reset never fakes an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sda_q <= 1'b1;
            scl_q <= 1'b1;
        end else begin
            sda_q <= sda_d;
            scl_q <= scl_d;
        end
    end

endmodule

// File: rtl/i2c_passthru_bus_monitor.sv
// I2C bus monitor: decodes conditions, bits, bytes and ACKs from filtered SDA/SCL.
module i2c_passthru_bus_monitor
    import i2c_passthru_pkg::*;
#(
    parameter int unsigned BYTE_CNT_WIDTH = 8,
    parameter int unsigned TIMEOUT_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CLKS   = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_sda,
    input  logic                      i_scl,
    output logic                      o_start,
    output logic                      o_rstart,
    output logic                      o_stop,
    output logic                      o_bit_valid,
    output logic                      o_bit,
    output logic                      o_byte_valid,
    output logic [7:0]                o_byte,
    output logic                      o_ack_valid,
    output logic                      o_ack,
    output logic                      o_addr_phase,
    output logic                      o_rw,
    output logic                      o_busy,
    output logic [3:0]                o_bit_idx,
    output logic [BYTE_CNT_WIDTH-1:0] o_byte_cnt,
    output logic                      o_timeout
);

    localparam bit                     TO_ON    = (TIMEOUT_CLKS != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CLKS);

    logic start, stop, rise, fall;

    state_e                    state_q, state_d;
    logic [3:0]                bit_idx_q, bit_idx_d;
    logic [BYTE_CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]                shift_q, shift_d;
    logic [7:0]                byte_q, byte_d;
    logic [TIMEOUT_WIDTH-1:0]  timer_q, timer_d;
    logic addr_phase_q, addr_phase_d, rw_q, rw_d, busy_q, busy_d;
    logic ack_q, ack_d, bit_q, bit_d;
    logic start_q, start_d, rstart_q, rstart_d, stop_q, stop_d;
    logic bit_valid_q, bit_valid_d, byte_valid_q, byte_valid_d;
    logic ack_valid_q, ack_valid_d, timeout_q, timeout_d;
    logic scl_activity, timeout_hit;

    i2c_passthru_edge_detect u_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_sda   (i_sda),
        .i_scl   (i_scl),
        .o_start (start),
        .o_stop  (stop),
        .o_rise  (rise),
        .o_fall  (fall)
    );

    // Next-state decode; START/STOP override any bit in progress.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        addr_phase_d = addr_phase_q;
        rw_d         = rw_q;
        busy_d       = busy_q;
        ack_d        = ack_q;
        bit_d        = bit_q;
        start_d      = 1'b0;
        rstart_d     = 1'b0;
        stop_d       = 1'b0;
        bit_valid_d  = 1'b0;
        byte_valid_d = 1'b0;
        ack_valid_d  = 1'b0;
        timeout_d    = 1'b0;

        scl_activity = rise | fall | start | stop;
        timeout_hit  = TO_ON && busy_q && !scl_activity
                       && ((timer_q + TIMEOUT_WIDTH'(1)) == TO_LIMIT);
        timer_d      = (scl_activity || !busy_q || timeout_hit) ? '0
                                                                : timer_q + TIMEOUT_WIDTH'(1);

        if (start) begin
            start_d      = 1'b1;
            rstart_d     = busy_q;
            state_d      = ST_DATA;
            bit_idx_d    = 4'd0;
            byte_cnt_d   = '0;
            shift_d      = 8'h00;
            addr_phase_d = 1'b1;
            rw_d         = 1'b0;
            busy_d       = 1'b1;
        end else if (stop) begin
            stop_d       = 1'b1;
            state_d      = ST_IDLE;
            bit_idx_d    = 4'd0;
            shift_d      = 8'h00;
            addr_phase_d = 1'b0;
            rw_d         = 1'b0;
            busy_d       = 1'b0;
        end else if (timeout_hit) begin
            timeout_d    = 1'b1;
            state_d      = ST_IDLE;
            bit_idx_d    = 4'd0;
            shift_d      = 8'h00;
            busy_d       = 1'b0;
        end else if (rise) begin
            unique case (state_q)
                ST_DATA: begin
                    shift_d     = {shift_q[6:0], i_sda};
                    bit_valid_d = 1'b1;
                    bit_d       = i_sda;
                    if (bit_idx_q == 4'd7) begin
                        byte_valid_d = 1'b1;
                        byte_d       = {shift_q[6:0], i_sda};
                        if (addr_phase_q) begin
                            rw_d = i_sda;
                        end
                        state_d   = ST_ACK;
                        bit_idx_d = ACK_BIT_IDX;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
                ST_ACK: begin
                    ack_valid_d  = 1'b1;
                    ack_d        = i_sda;
                    addr_phase_d = 1'b0;
                    if (byte_cnt_q != '1) begin
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_WIDTH'(1);
                    end
                    state_d   = ST_DATA;
                    bit_idx_d = 4'd0;
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= 4'd0;
            byte_cnt_q   <= '0;
            shift_q      <= 8'h00;
            byte_q       <= 8'h00;
            timer_q      <= '0;
            addr_phase_q <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= 1'b1;
            bit_q        <= 1'b0;
            start_q      <= 1'b0;
            rstart_q     <= 1'b0;
            stop_q       <= 1'b0;
            bit_valid_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            ack_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            timer_q      <= timer_d;
            addr_phase_q <= addr_phase_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            bit_q        <= bit_d;
            start_q      <= start_d;
            rstart_q     <= rstart_d;
            stop_q       <= stop_d;
            bit_valid_q  <= bit_valid_d;
            byte_valid_q <= byte_valid_d;
            ack_valid_q  <= ack_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_start      = start_q;
    assign o_rstart     = rstart_q;
    assign o_stop       = stop_q;
    assign o_bit_valid  = bit_valid_q;
    assign o_bit        = bit_q;
    assign o_byte_valid = byte_valid_q;
    assign o_byte       = byte_q;
    assign o_ack_valid  = ack_valid_q;
    assign o_ack        = ack_q;
    assign o_addr_phase = addr_phase_q;
    assign o_rw         = rw_q;
    assign o_busy       = busy_q;
    assign o_bit_idx    = bit_idx_q;
    assign o_byte_cnt   = byte_cnt_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_i2c_passthru_bus_monitor.sv
// Scoreboard bench for the I2C passthru bus monitor.
module tb_i2c_passthru_bus_monitor;

    localparam int K_START = 1;
    localparam int K_STOP  = 2;
    localparam int K_BIT   = 3;
    localparam int K_BYTE  = 4;
    localparam int K_ACK   = 5;
    localparam int K_TO    = 6;
    localparam int K_BOGUS = 7;
    localparam int TO_CLKS = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sda = 1'b1;
    logic       scl = 1'b1;
    logic       o_start, o_rstart, o_stop, o_bit_valid, o_bit, o_byte_valid;
    logic [7:0] o_byte;
    logic       o_ack_valid, o_ack, o_addr_phase, o_rw, o_busy, o_timeout;
    logic [3:0] o_bit_idx;
    logic [7:0] o_byte_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int cyc = 0;
    int last_edge = 0;
    logic scl_prev = 1'b1;

    i2c_passthru_bus_monitor #(
        .BYTE_CNT_WIDTH (8),
        .TIMEOUT_WIDTH  (16),
        .TIMEOUT_CLKS   (TO_CLKS)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sda        (sda),
        .i_scl        (scl),
        .o_start      (o_start),
        .o_rstart     (o_rstart),
        .o_stop       (o_stop),
        .o_bit_valid  (o_bit_valid),
        .o_bit        (o_bit),
        .o_byte_valid (o_byte_valid),
        .o_byte       (o_byte),
        .o_ack_valid  (o_ack_valid),
        .o_ack        (o_ack),
        .o_addr_phase (o_addr_phase),
        .o_rw         (o_rw),
        .o_busy       (o_busy),
        .o_bit_idx    (o_bit_idx),
        .o_byte_cnt   (o_byte_cnt),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int data);
        exp_q.push_back((kind << 8) | data);
    endtask

    task automatic expect_ev(input string tag, input int code);
        int e;
        e = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check_eq(tag, code, e);
    endtask

    task automatic drive(input logic s, input logic c, input int n);
        sda = s;
        scl = c;
        repeat (n) @(negedge clk);
    endtask

    // fast: raise SCL in the same sample that SDA changes
    task automatic send_bit(input logic b, input bit fast);
        if (!fast) drive(b, 1'b0, 2);
        drive(b, 1'b1, 2);
        drive(b, 1'b0, 2);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic ack, input bit fast);
        for (int i = 7; i >= 0; i--) begin
            push(K_BIT, int'(v[i]));
            if (i == 0) push(K_BYTE, int'(v));
            send_bit(v[i], fast);
        end
        push(K_ACK, int'(ack));
        send_bit(ack, 1'b0);
    endtask

    task automatic i2c_start(input bit busy);
        drive(1'b1, 1'b1, 2);
        push(K_START, int'(busy));
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 2);
    endtask

    // When busy, the SCL rise before the STOP is decoded as a data bit of 0.
    task automatic i2c_stop(input bit busy);
        drive(1'b0, 1'b0, 2);
        if (busy) push(K_BIT, 0);
        drive(1'b0, 1'b1, 2);
        push(K_STOP, 0);
        drive(1'b1, 1'b1, 2);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_busy"}, o_busy, 0);
        check_eq({tag, "_ack"}, o_ack, 1);
        check_eq({tag, "_byte"}, o_byte, 8'h00);
        check_eq({tag, "_idx"}, o_bit_idx, 0);
        check_eq({tag, "_cnt"}, o_byte_cnt, 0);
        check_eq({tag, "_rw"}, o_rw, 0);
        check_eq({tag, "_addr"}, o_addr_phase, 0);
        check_eq({tag, "_bit"}, o_bit, 0);
    endtask

    // Monitor: pop the scoreboard for every pulse the DUT produces.
    always begin
        @(posedge clk);
        cyc++;
        if (scl !== scl_prev) last_edge = cyc;
        scl_prev = scl;
        #1;
        if (o_start) expect_ev("start", (K_START << 8) | int'(o_rstart));
        if (o_rstart && !o_start) expect_ev("rstart_only", K_BOGUS << 8);
        if (o_stop) expect_ev("stop", K_STOP << 8);
        if (o_bit_valid) expect_ev("bit", (K_BIT << 8) | int'(o_bit));
        if (o_byte_valid) expect_ev("byte", (K_BYTE << 8) | int'(o_byte));
        if (o_ack_valid) expect_ev("ack", (K_ACK << 8) | int'(o_ack));
        if (o_timeout) begin
            expect_ev("timeout", K_TO << 8);
            check_eq("timeout_lat", cyc - last_edge, TO_CLKS);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        sda = 1'b1;
        scl = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("idle_busy", o_busy, 0);
        check_eq("idle_ack", o_ack, 1);

        // STOP on an idle bus still pulses; the preceding SCL rise is ignored.
        i2c_stop(1'b0);
        check_eq("idle_stop_busy", o_busy, 0);

        // Single address byte 0xA5 with ACK.
        i2c_start(1'b0);
        check_eq("a5_busy", o_busy, 1);
        check_eq("a5_addr0", o_addr_phase, 1);
        send_byte(8'hA5, 1'b0, 1'b0);
        check_eq("a5_byte", o_byte, 8'hA5);
        check_eq("a5_rw", o_rw, 1);
        check_eq("a5_ack", o_ack, 0);
        check_eq("a5_addr1", o_addr_phase, 0);
        check_eq("a5_cnt", o_byte_cnt, 1);
        i2c_stop(1'b1);
        check_eq("a5_stop_busy", o_busy, 0);
        check_eq("a5_stop_rw", o_rw, 0);

        // Two bytes then a repeated START part-way through a third.
        i2c_start(1'b0);
        send_byte(8'h50, 1'b0, 1'b0);
        check_eq("b2_rw", o_rw, 0);
        send_byte(8'h3C, 1'b1, 1'b0);
        check_eq("b2_ack", o_ack, 1);
        check_eq("b2_cnt", o_byte_cnt, 2);
        for (int i = 0; i < 3; i++) begin
            push(K_BIT, i % 2 == 0 ? 1 : 0);
            send_bit(i % 2 == 0, 1'b0);
        end
        push(K_BIT, 1);
        drive(1'b1, 1'b0, 2);
        drive(1'b1, 1'b1, 2);
        check_eq("rs_idx_before", o_bit_idx, 4);
        i2c_start(1'b1);
        check_eq("rs_idx", o_bit_idx, 0);
        check_eq("rs_cnt", o_byte_cnt, 0);
        check_eq("rs_addr", o_addr_phase, 1);
        check_eq("rs_busy", o_busy, 1);
        check_eq("rs_byte_held", o_byte, 8'h3C);
        i2c_stop(1'b1);

        // STOP after three bits of a byte.
        i2c_start(1'b0);
        push(K_BIT, 1);
        send_bit(1'b1, 1'b0);
        push(K_BIT, 1);
        send_bit(1'b1, 1'b0);
        i2c_stop(1'b1);
        check_eq("ms_busy", o_busy, 0);
        check_eq("ms_idx", o_bit_idx, 0);
        check_eq("ms_byte_held", o_byte, 8'h3C);

        // SCL stuck low while busy.
        i2c_start(1'b0);
        push(K_BIT, 1);
        send_bit(1'b1, 1'b0);
        push(K_BIT, 0);
        send_bit(1'b0, 1'b0);
        push(K_TO, 0);
        repeat (TO_CLKS + 10) @(negedge clk);
        check_eq("to_busy", o_busy, 0);
        check_eq("to_idx", o_bit_idx, 0);
        drive(1'b1, 1'b0, 2);
        drive(1'b1, 1'b1, 2);

        // Reset in the middle of a byte.
        i2c_start(1'b0);
        for (int i = 0; i < 5; i++) begin
            push(K_BIT, (i == 2 || i == 3) ? 0 : 1);
            send_bit(!(i == 2 || i == 3), 1'b0);
        end
        check_eq("mr_idx", o_bit_idx, 5);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mr");
        rst = 1'b0;
        drive(1'b1, 1'b0, 2);
        drive(1'b1, 1'b1, 2);

        // 0xFF with SCL rising in the same sample as SDA changes.
        i2c_start(1'b0);
        send_byte(8'hFF, 1'b0, 1'b1);
        check_eq("ff_byte", o_byte, 8'hFF);
        check_eq("ff_rw", o_rw, 1);
        check_eq("ff_cnt", o_byte_cnt, 1);
        i2c_stop(1'b1);
        check_eq("ff_busy", o_busy, 0);

        repeat (5) @(negedge clk);
        check_eq("q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_passthru_bus_monitor.md
Name: i2c_passthru_bus_monitor

Overview:
- Sits directly downstream of the input glitch filter and consumes its filtered o_sda/o_scl.
- Detects START, repeated START and STOP conditions, and samples data bits on SCL rising edges.
- Assembles bytes MSB-first, captures the ACK bit, and flags the address byte and R/W bit.
- Provides a bus-stuck timeout.
- Its event pulses drive the passthru direction/arbitration logic.

Parameters:
- BYTE_CNT_WIDTH, 8: width of o_byte_cnt; the count saturates at all-ones.
- TIMEOUT_WIDTH, 16: width of the internal idle-SCL timer.
- TIMEOUT_CLKS, 0: i_clk cycles without an SCL edge while busy before a forced return to IDLE. 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_sda  in  1  filtered SDA (already synchronised)
- i_scl  in  1  filtered SCL (already synchronised)
- o_start  out  1  1-cycle pulse on START or repeated START
- o_rstart  out  1  1-cycle pulse, asserted together with o_start only when busy
- o_stop  out  1  1-cycle pulse on STOP
- o_bit_valid  out  1  1-cycle pulse per data bit (bits 0..7 of a byte, not the ACK)
- o_bit  out  1  sampled data bit value, valid with o_bit_valid
- o_byte_valid  out  1  1-cycle pulse when the 8th data bit is sampled
- o_byte  out  8  assembled byte, held until the next o_byte_valid
- o_ack_valid  out  1  1-cycle pulse on the 9th SCL rise
- o_ack  out  1  SDA at the 9th rise (0 = ACK, 1 = NACK), held
- o_addr_phase  out  1  high from START until the first ACK completes
- o_rw  out  1  bit0 of the first byte after START; held until the next START/STOP
- o_busy  out  1  high between START and STOP/timeout
- o_bit_idx  out  4  current bit position 0..8
- o_byte_cnt  out  BYTE_CNT_WIDTH  bytes completed since START (saturating)
- o_timeout  out  1  1-cycle pulse when the timeout fires

Behaviour:
- Previous-sample registers sda_q and scl_q are updated every i_clk. Reset value is 1 for both (idle bus), so release from reset never yields a spurious edge.
- Events, from the current input versus the previous sample:
  - start = scl_q & i_scl & sda_q & ~i_sda
  - stop = scl_q & i_scl & ~sda_q & i_sda
  - rise = ~scl_q & i_scl
  - fall = scl_q & ~i_scl
- All outputs are registered. Latency is 1: a pulse is high in the cycle after the clock edge that first samples the input change.
- States: IDLE, DATA (o_bit_idx 0..7), ACK (o_bit_idx 8).
- IDLE:
  - start -> DATA, bit_idx=0, byte_cnt=0, addr_phase=1, busy=1, o_start pulse.
  - stop -> o_stop pulse, stay IDLE.
  - rise is ignored.
- DATA, on rise:
  - shift i_sda into the LSB and pulse o_bit_valid with o_bit=i_sda.
  - if bit_idx==7: o_byte_valid with o_byte = the completed byte. If addr_phase, o_rw=i_sda. Go to ACK, bit_idx=8.
  - otherwise bit_idx+1.
- ACK, on rise:
  - o_ack_valid, o_ack=i_sda, byte_cnt+1 (saturating), addr_phase=0.
  - -> DATA, bit_idx=0.
- START while busy, in any state: o_start and o_rstart pulse. Partial byte discarded (no byte_valid). bit_idx=0, byte_cnt=0, addr_phase=1, o_rw cleared -> DATA.
- STOP while busy, in any state: o_stop pulse, partial byte discarded, busy=0, addr_phase=0, o_rw=0 -> IDLE.
- Simultaneous SCL rise and SDA change in one sample: treated as a bit with the new SDA value. It is not a START/STOP, since those require SCL high in both samples.
- Timeout (TIMEOUT_CLKS>0):
  - The timer clears on rise, fall, start, stop, or when not busy. Otherwise it increments while busy.
  - At the count equal to TIMEOUT_CLKS: o_timeout pulse, -> IDLE, busy=0, partial byte discarded, no o_stop.
  - The timer is TIMEOUT_WIDTH bits; TIMEOUT_CLKS must be below 2^TIMEOUT_WIDTH.
- Reset values:
  - i_rst=1 at any point, including mid-byte: state IDLE next cycle.
  - All pulses 0; o_byte=0, o_ack=1, o_rw=0, o_busy=0, o_addr_phase=0, o_bit_idx=0, o_byte_cnt=0, o_bit=0.
  - Timer cleared.

Decomposition:
- Shared package i2c_passthru_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_DATA=2'd1, ST_ACK=2'd2
  - ACK_BIT_IDX=4'd8
- One natural sub-module: i2c_passthru_edge_detect. It holds sda_q/scl_q and produces start/stop/rise/fall combinationally, and is reused later by the output-side monitor.
- The timeout counter stays inline.

Test Plan:
- Reset 5 cycles, then idle bus high for 20 cycles -> no pulses; o_busy=0, o_ack=1.
- START, byte 0xA5, SDA=0 at 9th rise, STOP:
  - o_start, then 8 o_bit_valid with 1,0,1,0,0,1,0,1.
  - o_byte_valid with o_byte=0xA5; o_rw=1 is valid from the 8th-bit o_byte_valid.
  - o_ack_valid with o_ack=0; o_addr_phase drops after the ACK.
  - o_byte_cnt=1, then o_stop, o_busy=0.
- START, 0x50 ACK, 0x3C NACK, repeated START at bit_idx=4 of the third byte:
  - byte_valid 0x50 and 0x3C; o_ack 0 then 1; byte_cnt=2.
  - o_start+o_rstart pulse, no third byte_valid; bit_idx=0, byte_cnt=0, addr_phase=1.
- STOP mid-byte after 3 bits -> o_stop, no byte_valid, o_busy=0, state IDLE.
- TIMEOUT_CLKS=50: START, 2 bits, then SCL held low -> o_timeout exactly 50 cycles after the last SCL edge, o_busy=0, no o_stop.
- Assert i_rst mid-byte (bit_idx=5) -> next cycle all outputs at reset values. A subsequent START/0xFF byte decodes correctly.
